// File: rtl/regfile_sb_if.sv
// Decode-stage bus to regfile_sb: writeback, issue, two read ports and ready.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            ready;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            rs1_en;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic            rs2_en;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;

    modport master (
        input  ready, rs1_data, rs1_busy, rs2_data, rs2_busy,
        output we, waddr, wdata, iss_en, iss_addr,
               rs1_en, rs1_addr, rs2_en, rs2_addr
    );

    modport slave (
        output ready, rs1_data, rs1_busy, rs2_data, rs2_busy,
        input  we, waddr, wdata, iss_en, iss_addr,
               rs1_en, rs1_addr, rs2_en, rs2_addr
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and post-reset clear sequencer; x0 hardwired zero.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  rf
);
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [NREG-1:0] busy;
    logic            ready_q;
    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;
    logic            iss_ok;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;

    assign wr_en  = (state == READY) && rf.we && (rf.waddr != '0);
    assign iss_ok = (state == READY) && rf.iss_en && (rf.iss_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= AW'(1);
            busy    <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // counter parks at the last index instead of wrapping
                    if (clr_cnt == LAST) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    // issue is applied after writeback so a new producer wins
                    if (wr_en)
                        busy[rf.waddr] <= 1'b0;
                    if (iss_ok)
                        busy[rf.iss_addr] <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage has no reset; the clear sequence defines every entry before use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[clr_cnt] <= '0;
            else if (wr_en)
                regs[rf.waddr] <= rf.wdata;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if ((state == READY) && rf.rs1_en && (rf.rs1_addr != '0)) begin
`ifdef RF_BYPASS_EN
            if (wr_en && (rf.waddr == rf.rs1_addr)) begin
                rs1_data = rf.wdata;
                rs1_busy = 1'b0;
            end else begin
`else
            begin
`endif
                rs1_data = regs[rf.rs1_addr];
                rs1_busy = busy[rf.rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if ((state == READY) && rf.rs2_en && (rf.rs2_addr != '0)) begin
`ifdef RF_BYPASS_EN
            if (wr_en && (rf.waddr == rf.rs2_addr)) begin
                rs2_data = rf.wdata;
                rs2_busy = 1'b0;
            end else begin
`else
            begin
`endif
                rs2_data = regs[rf.rs2_addr];
                rs2_busy = busy[rf.rs2_addr];
            end
        end
    end

    assign rf.ready    = ready_q;
    assign rf.rs1_data = rs1_data;
    assign rf.rs1_busy = rs1_busy;
    assign rf.rs2_data = rs2_data;
    assign rf.rs2_busy = rs2_busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: clear sequence, scoreboard, x0 and reset-restart.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    regfile_sb_if #(.XLEN(32), .AW(5)) rf ();

    regfile_sb #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        iss;
        logic [4:0]  iaddr;
        logic        e1;
        logic [4:0]  a1;
        logic        e2;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rf.we = 1'b0; rf.waddr = '0; rf.wdata = '0;
        rf.iss_en = 1'b0; rf.iss_addr = '0;
        rf.rs1_en = 1'b0; rf.rs1_addr = '0;
        rf.rs2_en = 1'b0; rf.rs2_addr = '0;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            chk({tag, "_ready"}, {31'b0, rf.ready}, {31'b0, (i == 31)});
            if (i < 31) begin
                chk({tag, "_clr_rs1_data"}, rf.rs1_data, 32'h0);
                chk({tag, "_clr_rs1_busy"}, {31'b0, rf.rs1_busy}, 32'h0);
            end
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        idle();

        // reset with writeback/issue to x4 held active through the clear
        rf.we = 1'b1; rf.waddr = 5'd4; rf.wdata = 32'hFF;
        rf.iss_en = 1'b1; rf.iss_addr = 5'd4;
        rf.rs1_en = 1'b1; rf.rs1_addr = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, rf.ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("init");

        @(negedge clk);
        idle();
        rf.rs1_en = 1'b1; rf.rs2_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rf.rs1_addr = 5'(a);
            rf.rs2_addr = 5'(31 - a);
            #1;
            chk("sweep_rs1_data", rf.rs1_data, 32'h0);
            chk("sweep_rs1_busy", {31'b0, rf.rs1_busy}, 32'h0);
            chk("sweep_rs2_data", rf.rs2_data, 32'h0);
            chk("sweep_rs2_busy", {31'b0, rf.rs2_busy}, 32'h0);
        end

        // write x5 and read it in the same cycle
        @(negedge clk);
        idle();
        rf.we = 1'b1; rf.waddr = 5'd5; rf.wdata = 32'hDEADBEEF;
        rf.rs1_en = 1'b1; rf.rs1_addr = 5'd5;
        #1;
`ifdef RF_BYPASS_EN
        chk("wr_same_cycle", rf.rs1_data, 32'hDEADBEEF);
`else
        chk("wr_same_cycle", rf.rs1_data, 32'h0);
`endif
        chk("wr_same_cycle_busy", {31'b0, rf.rs1_busy}, 32'h0);
        @(negedge clk);
        rf.we = 1'b0;
        #1;
        chk("wr_next_cycle", rf.rs1_data, 32'hDEADBEEF);

        //          we    wa     wdata          iss   ia     e1    a1     e2    a2     d1            b1    d2            b2
        tbl[0]  = '{1'b1, 5'd0,  32'h1234,      1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        1'b0, 32'h0,        1'b1};
        tbl[3]  = '{1'b1, 5'd7,  32'h55,        1'b0, 5'd0,  1'b1, 5'd5,  1'b1, 5'd9,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 5'd9,  32'h99,        1'b1, 5'd9,  1'b1, 5'd7,  1'b1, 5'd3,  32'h55,       1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd9,  1'b1, 5'd7,  32'h99,       1'b1, 32'h55,       1'b0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd9,  1'b1, 5'd9,  32'h0,        1'b0, 32'h99,       1'b1};
        tbl[7]  = '{1'b1, 5'd3,  32'hAA,        1'b1, 5'd3,  1'b1, 5'd9,  1'b1, 5'd7,  32'h99,       1'b1, 32'h55,       1'b0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b1, 5'd3,  1'b1, 5'd9,  32'hAA,       1'b1, 32'h99,       1'b1};
        tbl[9]  = '{1'b1, 5'd9,  32'h77,        1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 5'd5,  32'hAA,       1'b1, 32'hDEADBEEF, 1'b0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd9,  1'b1, 5'd0,  32'h77,       1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd3,  1'b0, 5'd9,  32'h0,        1'b0, 32'h0,        1'b0};

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            rf.we = tbl[v].we; rf.waddr = tbl[v].waddr; rf.wdata = tbl[v].wdata;
            rf.iss_en = tbl[v].iss; rf.iss_addr = tbl[v].iaddr;
            rf.rs1_en = tbl[v].e1; rf.rs1_addr = tbl[v].a1;
            rf.rs2_en = tbl[v].e2; rf.rs2_addr = tbl[v].a2;
            #1;
            chk($sformatf("v%0d_rs1_data", v), rf.rs1_data, tbl[v].d1);
            chk($sformatf("v%0d_rs1_busy", v), {31'b0, rf.rs1_busy}, {31'b0, tbl[v].b1});
            chk($sformatf("v%0d_rs2_data", v), rf.rs2_data, tbl[v].d2);
            chk($sformatf("v%0d_rs2_busy", v), {31'b0, rf.rs2_busy}, {31'b0, tbl[v].b2});
        end

        // writeback and re-issue of busy x3 while reading it
        @(negedge clk);
        idle();
        rf.we = 1'b1; rf.waddr = 5'd3; rf.wdata = 32'hBB;
        rf.iss_en = 1'b1; rf.iss_addr = 5'd3;
        rf.rs1_en = 1'b1; rf.rs1_addr = 5'd3;
        #1;
`ifdef RF_BYPASS_EN
        chk("wb_iss_x3_data", rf.rs1_data, 32'hBB);
        chk("wb_iss_x3_busy", {31'b0, rf.rs1_busy}, 32'h0);
`else
        chk("wb_iss_x3_data", rf.rs1_data, 32'hAA);
        chk("wb_iss_x3_busy", {31'b0, rf.rs1_busy}, 32'h1);
`endif
        @(negedge clk);
        rf.we = 1'b0; rf.iss_en = 1'b0;
        #1;
        chk("x3_after_data", rf.rs1_data, 32'hBB);
        chk("x3_after_busy", {31'b0, rf.rs1_busy}, 32'h1);

        // reset mid-traffic restarts the clear
        @(negedge clk);
        rst = 1'b1;
        rf.rs2_en = 1'b1; rf.rs2_addr = 5'd9;
        @(posedge clk); #1;
        chk("rst2_ready", {31'b0, rf.ready}, 32'h0);
        chk("rst2_x3_data", rf.rs1_data, 32'h0);
        chk("rst2_x3_busy", {31'b0, rf.rs1_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("rst2");
        #1;
        chk("post_x3_data", rf.rs1_data, 32'h0);
        chk("post_x3_busy", {31'b0, rf.rs1_busy}, 32'h0);
        chk("post_x9_data", rf.rs2_data, 32'h0);
        chk("post_x9_busy", {31'b0, rf.rs2_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end
endmodule
